// File: rtl/rf_pkg.sv
// Shared definitions for the threaded register file: default sizing, clear-engine states, entry indexing.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rf_pkg;

    localparam int RF_DATA_W      = 32;
    localparam int RF_NUM_REGS    = 32;
    localparam int RF_NUM_THREADS = 4;
    localparam int RF_NUM_RD      = 2;
    localparam int RF_ZERO_REG    = 1;

    // CLR_ALL: post-reset sweep of every entry; CLR_CTX: sweep of one thread context.
    typedef enum logic [1:0] {
        CLR_ALL = 2'd0,
        IDLE    = 2'd1,
        CLR_CTX = 2'd2
    } rf_state_e;

    // Flat storage index of register <addr> in context <tid>, i.e. {tid, addr}.
    // Callers truncate to the storage index width, which also folds tid away
    // when there is only one context.
    function automatic int unsigned rf_idx(input int unsigned tid,
                                           input int unsigned addr,
                                           input int unsigned num_regs);
        return tid * num_regs + addr;
    endfunction

endpackage

// File: rtl/rf_clear_ctrl.sv
// Clear engine: after reset zeroes every entry, and on request zeroes one thread context, one entry per cycle.
// Latency: clear_all takes NUM_THREADS*NUM_REGS cycles, a context clear NUM_REGS cycles after the accepting edge.
// Backpressure: ready=0 while sweeping; clr_req outside IDLE is ignored, nothing is queued.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   clr_req        request to clear context clr_tid (accepted only in IDLE)
//   clr_tid        context to clear
//   ready          1 = idle (registered)
//   clr_we         1 = write zero to clr_idx this cycle (registered)
//   clr_idx        storage index being cleared
module rf_clear_ctrl
    import rf_pkg::*;
#(
    parameter  int NUM_REGS    = RF_NUM_REGS,
    parameter  int NUM_THREADS = RF_NUM_THREADS,
    localparam int TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int CW          = $clog2(NUM_THREADS * NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    input  logic [TW-1:0] clr_tid,
    output logic          ready,
    output logic          clr_we,
    output logic [CW-1:0] clr_idx
);

    localparam logic [CW-1:0] LAST_ALL = CW'(NUM_THREADS * NUM_REGS - 1);
    localparam logic [CW-1:0] LAST_CTX = CW'(NUM_REGS - 1);

    rf_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tid_q, tid_d;
    logic          ready_q, ready_d;
    logic          clr_we_q, clr_we_d;

    // Terminal compare happens before the increment, so the counter never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tid_d   = tid_q;
        case (state_q)
            CLR_ALL: begin
                if (cnt_q == LAST_ALL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_d = CLR_CTX;
                    cnt_d   = '0;
                    tid_d   = clr_tid;
                end
            end
            CLR_CTX: begin
                if (cnt_q == LAST_CTX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = CLR_ALL;
                cnt_d   = '0;
            end
        endcase
        // Outputs are registered: they follow the state being entered.
        ready_d  = (state_d == IDLE);
        clr_we_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= CLR_ALL;
            cnt_q    <= '0;
            tid_q    <= '0;
            ready_q  <= 1'b0;
            clr_we_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tid_q    <= tid_d;
            ready_q  <= ready_d;
            clr_we_q <= clr_we_d;
        end
    end

    assign ready   = ready_q;
    assign clr_we  = clr_we_q;
    // In CLR_ALL the counter spans all entries; in CLR_CTX it spans one context.
    assign clr_idx = (state_q == CLR_CTX)
                   ? CW'(rf_idx(32'(tid_q), 32'(cnt_q), NUM_REGS))
                   : cnt_q;

endmodule

// File: rtl/threaded_register_file.sv
// Multi-context register file: one register set per hardware thread, NUM_RD read ports, one write port.
// Latency: reads combinational (write-to-read bypass in the same cycle), writes visible from storage next cycle.
// Backpressure: ready=0 while the clear engine runs; reads then return 0 and writes are dropped.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   rd_tid/rd_addr/rd_data     flattened per-port read request and data, port 0 in LSBs
//   we/wr_tid/wr_addr/wr_data  write port
//   clr_req/clr_tid            request zeroing of one context
//   ready                      1 = idle, writes accepted and reads valid
module threaded_register_file
    import rf_pkg::*;
#(
    parameter  int DATA_W      = RF_DATA_W,
    parameter  int NUM_REGS    = RF_NUM_REGS,
    parameter  int NUM_THREADS = RF_NUM_THREADS,
    parameter  int NUM_RD      = RF_NUM_RD,
    parameter  int ZERO_REG    = RF_ZERO_REG,
    localparam int AW          = $clog2(NUM_REGS),
    localparam int TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int CW          = $clog2(NUM_THREADS * NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*TW-1:0]     rd_tid,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we,
    input  logic [TW-1:0]            wr_tid,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
    input  logic [TW-1:0]            clr_tid,
    output logic                     ready
);

    localparam int NUM_ENTRIES = NUM_THREADS * NUM_REGS;

    logic          clr_we;
    logic [CW-1:0] clr_idx;

    rf_clear_ctrl #(
        .NUM_REGS    (NUM_REGS),
        .NUM_THREADS (NUM_THREADS)
    ) u_clear_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .clr_tid (clr_tid),
        .ready   (ready),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    logic [CW-1:0] wr_idx;
    logic          wr_commit;

    assign wr_idx    = CW'(rf_idx(32'(wr_tid), 32'(wr_addr), NUM_REGS));
    assign wr_commit = we && ready && !((ZERO_REG != 0) && (wr_addr == '0));

    // clr_we is only high outside IDLE and wr_commit only inside it, so the
    // priority below never actually arbitrates; it just keeps the mux simple.
    logic              mem_we_d;
    logic [CW-1:0]     mem_idx_d;
    logic [DATA_W-1:0] mem_dat_d;

    always_comb begin
        mem_we_d  = 1'b0;
        mem_idx_d = wr_idx;
        mem_dat_d = wr_data;
        if (clr_we) begin
            mem_we_d  = 1'b1;
            mem_idx_d = clr_idx;
            mem_dat_d = '0;
        end else if (wr_commit) begin
            mem_we_d = 1'b1;
        end
    end

    // Storage has no reset; the clear engine initialises it.
    logic [DATA_W-1:0] mem_q [NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_idx_d] <= mem_dat_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [TW-1:0]     tid;
        logic [AW-1:0]     addr;
        logic [CW-1:0]     idx;
        logic [DATA_W-1:0] dat;

        assign tid  = rd_tid[p*TW +: TW];
        assign addr = rd_addr[p*AW +: AW];
        assign idx  = CW'(rf_idx(32'(tid), 32'(addr), NUM_REGS));

        // Index compare (not tid/addr compare) keeps the bypass correct when
        // a single context folds the tid bits away.
        always_comb begin
            if (!ready) begin
                dat = '0;
            end else if ((ZERO_REG != 0) && (addr == '0)) begin
                dat = '0;
            end else if (wr_commit && (wr_idx == idx)) begin
                dat = wr_data;
            end else begin
                dat = mem_q[idx];
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = dat;
    end

endmodule
